// File: rtl/mips_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_pkg
// Description : Shared types and constants for the mips_cpu_bus memory port:
//               arbiter state encoding, requester identifiers and the
//               all-lanes byte-enable constant.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_bus_pkg;

  // Arbiter sequencing states; explicit width keeps the encoding fixed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  // Identifies which internal requester owns the current bus transaction.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  // Widest byte-enable vector supported; users slice the low BE_W bits.
  localparam int unsigned MAX_BE_W = 16;
  localparam logic [MAX_BE_W-1:0] BE_ALL = '1;

  // Starvation counter width; covers STARVE_LIMIT values 1..15.
  localparam int unsigned STARVE_CNT_W = 4;

endpackage : mips_bus_pkg
`default_nettype wire

// File: rtl/mips_avalon_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_avalon_arbiter
// Description : Shares one Avalon-MM master port between instruction fetch
//               (I) and load/store data (D). One transaction at a time,
//               level req / one-cycle ack handshake, fixed D-over-I priority
//               with a starvation override that forces an I grant after
//               STARVE_LIMIT consecutive D grants while I is waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_avalon_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,

  // instruction fetch requester
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,

  // load/store requester
  input  logic                d_req,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byteen,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,

  // Avalon-MM master
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int unsigned             BE_W    = DATA_W / 8;
  localparam logic [STARVE_CNT_W-1:0] C_LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_t              r_state;
  req_id_t                 r_owner;
  logic [STARVE_CNT_W-1:0] r_starve_cnt;

  logic w_starved;
  logic w_grant_d;
  logic w_grant_i;

  // Winner select: D wins unless a waiting fetch has hit the starvation limit.
  always_comb begin
    w_starved = i_req && (r_starve_cnt == C_LIMIT);
    w_grant_d = d_req && !w_starved;
    w_grant_i = i_req && !w_grant_d;
  end

  // Transaction sequencer: grant in IDLE, hold command through stalls in BUS,
  // single-cycle ack and a dead ACK cycle before the next grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_owner      <= REQ_I;
      r_starve_cnt <= '0;
      address      <= '0;
      read         <= 1'b0;
      write        <= 1'b0;
      writedata    <= '0;
      byteenable   <= '0;
      i_ack        <= 1'b0;
      d_ack        <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      // acks are single-cycle pulses unless set below
      i_ack <= 1'b0;
      d_ack <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            address    <= d_addr;
            writedata  <= d_wdata;
            byteenable <= d_byteen;
            read       <= !d_write;
            write      <= d_write;
            r_owner    <= REQ_D;
            r_state    <= BUS;
            // count D wins only while a fetch is left waiting
            if (i_req) begin
              if (r_starve_cnt != C_LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
              end
            end else begin
              r_starve_cnt <= '0;
            end
          end else if (w_grant_i) begin
            address      <= i_addr;
            byteenable   <= BE_ALL[BE_W-1:0];
            read         <= 1'b1;
            write        <= 1'b0;
            r_owner      <= REQ_I;
            r_state      <= BUS;
            r_starve_cnt <= '0;
          end else begin
            r_starve_cnt <= '0;
          end
        end

        BUS: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            if (read) begin
              if (r_owner == REQ_I) begin
                i_rdata <= readdata;
              end else begin
                d_rdata <= readdata;
              end
            end
            if (r_owner == REQ_I) begin
              i_ack <= 1'b1;
            end else begin
              d_ack <= 1'b1;
            end
            r_state <= ACK;
          end
        end

        ACK: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : mips_avalon_arbiter
`default_nettype wire

// File: tb/tb_mips_avalon_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_avalon_arbiter
// Description : Self-checking bench for mips_avalon_arbiter. Expected
//               transactions are queued when requests are driven and popped
//               when the matching ack appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_avalon_arbiter;
  import mips_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteen;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  typedef struct {
    req_id_t     id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_i_rdata;
  logic [31:0] exp_d_rdata;

  mips_avalon_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_ack      (i_ack),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_byteen   (d_byteen),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .address    (address),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .byteenable (byteenable),
    .waitrequest(waitrequest),
    .readdata   (readdata)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({read, write} !== 2'b00) begin n_err++; $display("FAIL rst_strobes: got %b want 00", {read, write}); end
    n_cmp++; if (address !== 32'h0) begin n_err++; $display("FAIL rst_address: got %h want 0", address); end
    n_cmp++; if (writedata !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", writedata); end
    n_cmp++; if (byteenable !== 4'h0) begin n_err++; $display("FAIL rst_be: got %h want 0", byteenable); end
    n_cmp++; if ({i_ack, d_ack} !== 2'b00) begin n_err++; $display("FAIL rst_acks: got %b want 00", {i_ack, d_ack}); end
    n_cmp++; if ({i_rdata, d_rdata} !== 64'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", {i_rdata, d_rdata}); end
    reset = 1'b1;
    exp_i_rdata = 32'h0;
    exp_d_rdata = 32'h0;
  endtask

  task automatic test_reset_mid_bus();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_1000; waitrequest = 1'b1;
    @(negedge clk);
    n_cmp++; if (read !== 1'b1) begin n_err++; $display("FAIL mid_read_up: got %b want 1", read); end
    reset = 1'b0;
    #1;
    n_cmp++; if (read !== 1'b0) begin n_err++; $display("FAIL mid_read_drop: got %b want 0", read); end
    n_cmp++; if (address !== 32'h0) begin n_err++; $display("FAIL mid_addr_clr: got %h want 0", address); end
    repeat (2) begin
      @(negedge clk);
      n_cmp++; if ({i_ack, d_ack} !== 2'b00) begin n_err++; $display("FAIL mid_no_ack: got %b want 00", {i_ack, d_ack}); end
    end
    i_req = 1'b0; waitrequest = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({read, write, i_ack, d_ack} !== 4'b0000) begin n_err++; $display("FAIL mid_idle: got %b want 0000", {read, write, i_ack, d_ack}); end
  endtask

  task automatic test_i_read();
    exp_t e;
    exp_q.push_back('{REQ_I, 1'b0, 32'hBFC0_0000, 32'h0, 4'hF, 32'h8C01_0064});
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'hBFC0_0000; waitrequest = 1'b0; readdata = 32'h8C01_0064;
    @(negedge clk);
    n_cmp++; if ({read, write} !== 2'b10) begin n_err++; $display("FAIL ir_strobe: got %b want 10", {read, write}); end
    n_cmp++; if ({address, byteenable} !== {exp_q[0].addr, exp_q[0].be}) begin n_err++; $display("FAIL ir_fields: got %h want %h", {address, byteenable}, {exp_q[0].addr, exp_q[0].be}); end
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++; if ({i_ack, d_ack, read} !== 3'b100) begin n_err++; $display("FAIL ir_ack: got %b want 100", {i_ack, d_ack, read}); end
    n_cmp++; if (i_rdata !== e.rdata) begin n_err++; $display("FAIL ir_rdata: got %h want %h", i_rdata, e.rdata); end
    exp_i_rdata = e.rdata;
    i_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (i_ack !== 1'b0) begin n_err++; $display("FAIL ir_ack_once: got %b want 0", i_ack); end
  endtask

  task automatic test_d_write_stall();
    exp_t e;
    exp_q.push_back('{REQ_D, 1'b1, 32'h0000_00C8, 32'd123, 4'b0001, exp_d_rdata});
    @(negedge clk);
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h0000_00C8; d_wdata = 32'd123; d_byteen = 4'b0001;
    waitrequest = 1'b1; readdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++; if ({read, write, d_ack} !== 3'b010) begin n_err++; $display("FAIL dw_strobe: cyc %0d got %b want 010", k, {read, write, d_ack}); end
      n_cmp++; if ({address, writedata, byteenable} !== {exp_q[0].addr, exp_q[0].wdata, exp_q[0].be}) begin
        n_err++; $display("FAIL dw_fields: cyc %0d got %h want %h", k, {address, writedata, byteenable}, {exp_q[0].addr, exp_q[0].wdata, exp_q[0].be});
      end
      // requester changes and drops its request mid-transaction
      if (k == 2) begin d_req = 1'b0; d_addr = 32'h5555_5555; d_wdata = 32'h0; d_byteen = 4'hF; end
      if (k == 4) waitrequest = 1'b0;
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++; if ({d_ack, i_ack, write} !== 3'b100) begin n_err++; $display("FAIL dw_ack: got %b want 100", {d_ack, i_ack, write}); end
    n_cmp++; if (d_rdata !== e.rdata) begin n_err++; $display("FAIL dw_rdata_hold: got %h want %h", d_rdata, e.rdata); end
    @(negedge clk);
    n_cmp++; if (d_ack !== 1'b0) begin n_err++; $display("FAIL dw_ack_once: got %b want 0", d_ack); end
  endtask

  task automatic test_d_read_after_write();
    exp_t e;
    exp_q.push_back('{REQ_D, 1'b1, 32'h0000_0100, 32'h0000_ABCD, 4'hF, exp_d_rdata});
    exp_q.push_back('{REQ_D, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'hF, 32'd404});
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      d_req = 1'b1; d_write = exp_q[0].wr; d_addr = exp_q[0].addr; d_wdata = exp_q[0].wdata;
      d_byteen = exp_q[0].be; waitrequest = 1'b0; readdata = 32'd404;
      @(negedge clk);
      n_cmp++; if ({read, write} !== {!exp_q[0].wr, exp_q[0].wr}) begin n_err++; $display("FAIL rw_strobe: txn %0d got %b want %b", j, {read, write}, {!exp_q[0].wr, exp_q[0].wr}); end
      n_cmp++; if (address !== exp_q[0].addr) begin n_err++; $display("FAIL rw_addr: txn %0d got %h want %h", j, address, exp_q[0].addr); end
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++; if ({d_ack, read, write} !== 3'b100) begin n_err++; $display("FAIL rw_ack: txn %0d got %b want 100", j, {d_ack, read, write}); end
      n_cmp++; if (d_rdata !== e.rdata) begin n_err++; $display("FAIL rw_rdata: txn %0d got %h want %h", j, d_rdata, e.rdata); end
      n_cmp++; if (i_rdata !== exp_i_rdata) begin n_err++; $display("FAIL rw_irdata_hold: txn %0d got %h want %h", j, i_rdata, exp_i_rdata); end
      exp_d_rdata = e.rdata;
      d_req = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_priority();
    exp_t e;
    req_id_t order [6];
    int got;
    order = '{REQ_D, REQ_D, REQ_D, REQ_D, REQ_I, REQ_D};
    for (int j = 0; j < 6; j++) begin
      if (order[j] == REQ_D) exp_q.push_back('{REQ_D, 1'b0, 32'h0000_2000, 32'h0, 4'h3, 32'h0BAD_F00D});
      else                   exp_q.push_back('{REQ_I, 1'b0, 32'hBFC0_0040, 32'h0, 4'hF, 32'h0BAD_F00D});
    end
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'hBFC0_0040;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_2000; d_byteen = 4'h3;
    waitrequest = 1'b0; readdata = 32'h0BAD_F00D;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      n_cmp++; if (read && write) begin n_err++; $display("FAIL prio_excl: got rd=%b wr=%b want not both", read, write); end
      if (read) begin
        n_cmp++; if ({address, byteenable} !== {exp_q[0].addr, exp_q[0].be}) begin
          n_err++; $display("FAIL prio_grant: grant %0d got %h want %h", got, {address, byteenable}, {exp_q[0].addr, exp_q[0].be});
        end
      end
      if (i_ack || d_ack) begin
        e = exp_q.pop_front();
        n_cmp++; if ({i_ack, d_ack} !== ((e.id == REQ_I) ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL prio_order: ack %0d got %b want %b", got, {i_ack, d_ack}, (e.id == REQ_I) ? 2'b10 : 2'b01);
        end
        got++;
      end
    end
    n_cmp++; if (got != 6) begin n_err++; $display("FAIL prio_timeout: got %0d acks want 6", got); end
    exp_q.delete();
    exp_i_rdata = 32'h0BAD_F00D;
    exp_d_rdata = 32'h0BAD_F00D;
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int got, last_cyc;
    logic prev_ack;
    for (int j = 0; j < 4; j++) exp_q.push_back('{REQ_I, 1'b0, 32'hBFC0_0100, 32'h0, 4'hF, 32'h7000_0000 + 32'(j)});
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'hBFC0_0100; d_req = 1'b0; waitrequest = 1'b0; readdata = exp_q[0].rdata;
    got = 0; last_cyc = -1; prev_ack = 1'b0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      if (prev_ack) begin
        n_cmp++; if ({read, write} !== 2'b00) begin n_err++; $display("FAIL b2b_ack_gap: got %b want 00", {read, write}); end
      end
      prev_ack = i_ack;
      if (i_ack) begin
        e = exp_q.pop_front();
        n_cmp++; if (i_rdata !== e.rdata) begin n_err++; $display("FAIL b2b_rdata: ack %0d got %h want %h", got, i_rdata, e.rdata); end
        if (last_cyc >= 0) begin
          n_cmp++; if (cyc - last_cyc != 3) begin n_err++; $display("FAIL b2b_period: got %0d want 3", cyc - last_cyc); end
        end
        last_cyc = cyc;
        got++;
        if (exp_q.size() > 0) readdata = exp_q[0].rdata;
      end
    end
    n_cmp++; if (got != 4) begin n_err++; $display("FAIL b2b_timeout: got %0d acks want 4", got); end
    exp_q.delete();
    i_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; d_byteen = '0; waitrequest = 1'b0; readdata = '0;
    exp_i_rdata = '0; exp_d_rdata = '0;
    test_reset();
    test_reset_mid_bus();
    test_i_read();
    test_d_write_stall();
    test_d_read_after_write();
    test_priority();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mips_avalon_arbiter
`default_nettype wire
